// File: rtl/frame_pkg.sv
// Shared definitions for the frame stage controller.
// Pack layout {r,g,b,vs,hs,de,rsv,x,y}, y in the LSBs.
package frame_pkg;

    typedef enum logic {IDLE, ARMED} stage_state_t;

    localparam int Y_LSB = 0;

    function automatic int pack_width(input int h_act, input int v_act);
        return 3*8 + 4 + $clog2(h_act) + $clog2(v_act);
    endfunction

    function automatic int x_lsb(input int v_act);
        return $clog2(v_act);
    endfunction

    function automatic int de_bit(input int h_act, input int v_act);
        return $clog2(v_act) + $clog2(h_act) + 1;
    endfunction

    function automatic int hs_bit(input int h_act, input int v_act);
        return de_bit(h_act, v_act) + 1;
    endfunction

    function automatic int vs_bit(input int h_act, input int v_act);
        return de_bit(h_act, v_act) + 2;
    endfunction

    function automatic int rgb_msb(input int h_act, input int v_act);
        return pack_width(h_act, v_act) - 1;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Key synchroniser and tick-sampled debouncer for a vector of keys.
// Emits a one-cycle rise pulse when a key becomes debounced-pressed.
module key_debounce #(
    parameter int N    = 4,
    parameter int TICK = 500_000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] keys,
    output logic [N-1:0] rise
);

    localparam int CW = $clog2(TICK);
    localparam logic [CW-1:0] LAST = CW'(TICK - 1);

    logic [CW-1:0] cnt;
    logic          tick_hit;
    logic [N-1:0]  s1;
    logic [N-1:0]  s2;
    logic [N-1:0]  last;
    logic [N-1:0]  deb;

    assign tick_hit = (cnt == LAST);

    // Shared sample-tick counter, wraps at TICK-1.
    always_ff @(posedge clk) begin
        if (rst) cnt <= '0;
        else     cnt <= tick_hit ? '0 : cnt + 1'b1;
    end

    // Two-flop synchroniser for the asynchronous keys.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= keys;
            s2 <= s1;
        end
    end

    // History is {last, s2}: set on 11, clear on 00, else hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            last <= '0;
            deb  <= '0;
        end else if (tick_hit) begin
            last <= s2;
            deb  <= (last & s2) | (deb & (last | s2));
        end
    end

    assign rise = {N{tick_hit}} & last & s2 & ~deb;

endmodule

// File: rtl/frame_stage_ctrl.sv
// Key-driven stage enables committed at frame boundaries.
// Macro FRAME_STAGE_SYNC_EN selects frame-boundary commit.
module frame_stage_ctrl
    import frame_pkg::*;
#(
    parameter int                    NUM_STAGES = 4,
    parameter int                    TICK       = 500_000,
    parameter logic [NUM_STAGES-1:0] INIT       = '0,
    parameter int                    H_ACT      = 1280,
    parameter int                    V_ACT      = 720,
    localparam int                   PACK_W     = pack_width(H_ACT, V_ACT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_STAGES-1:0] keys,
    input  logic [PACK_W-1:0]     i_pack,
    output logic [PACK_W-1:0]     o_pack,
    output logic [NUM_STAGES-1:0] o_en,
    output logic [NUM_STAGES-1:0] o_pend,
    output logic                  o_wb_update,
    output logic [15:0]           o_frame_cnt
);

    localparam int VS_BIT = vs_bit(H_ACT, V_ACT);

    logic [NUM_STAGES-1:0] rise;
    logic                  vs_prev;
    logic                  frame_start;
    logic                  clr_cnt;

    key_debounce #(
        .N    (NUM_STAGES),
        .TICK (TICK)
    ) u_deb (
        .clk  (clk),
        .rst  (rst),
        .keys (keys),
        .rise (rise)
    );

    assign frame_start = i_pack[VS_BIT] & ~vs_prev;

    // Pack retiming and frame-start strobe; vs_prev resets high
    // so vs already high at reset release is not a frame start.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_pack      <= '0;
            o_wb_update <= 1'b0;
            vs_prev     <= 1'b1;
        end else begin
            o_pack      <= i_pack;
            o_wb_update <= frame_start;
            vs_prev     <= i_pack[VS_BIT];
        end
    end

    // Each debounced press toggles its pending enable.
    always_ff @(posedge clk) begin
        if (rst) o_pend <= INIT;
        else     o_pend <= o_pend ^ rise;
    end

`ifdef FRAME_STAGE_SYNC_EN
    stage_state_t state;
    stage_state_t state_nx;
    logic         commit;

    // Frame state register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Arm on pending change, commit on the next frame start.
    always_comb begin
        state_nx = state;
        commit   = 1'b0;
        unique case (state)
            IDLE: begin
                if (o_pend != o_en) begin
                    if (frame_start) commit   = 1'b1;
                    else             state_nx = ARMED;
                end
            end
            ARMED: begin
                if (frame_start) begin
                    commit   = (o_pend != o_en);
                    state_nx = IDLE;
                end else if (o_pend == o_en) begin
                    state_nx = IDLE;
                end
            end
        endcase
    end

    // Committed enables load only at a frame boundary.
    always_ff @(posedge clk) begin
        if (rst)         o_en <= INIT;
        else if (commit) o_en <= o_pend;
    end

    assign clr_cnt = commit;
`else
    // Enables follow pending with one cycle of latency.
    always_ff @(posedge clk) begin
        if (rst) o_en <= INIT;
        else     o_en <= o_pend;
    end

    assign clr_cnt = (o_en != o_pend);
`endif

    // Frames since the last enable change, saturating.
    always_ff @(posedge clk) begin
        if (rst)
            o_frame_cnt <= '0;
        else if (clr_cnt)
            o_frame_cnt <= '0;
        else if (frame_start && o_frame_cnt != 16'hFFFF)
            o_frame_cnt <= o_frame_cnt + 16'd1;
    end

endmodule

// File: doc/frame_stage_ctrl.md
Name: frame_stage_ctrl

Overview:
- Parametrised successor to the per-stage key toggles in the frame-processing chain.
- Debounces NUM_STAGES push keys and converts them into toggle-enable bits, one per processing stage (gamma, white balance, gray, face, ...).
- Enable changes are committed only at a frame boundary, so no frame is processed with mixed settings.
- Re-times the video pack by one register stage, aligned with the committed enables, and emits a one-cycle white-balance update strobe at each frame start.

Parameters:
- NUM_STAGES, 4, number of key-controlled stages (1..16).
- TICK, 500_000, clk cycles between debounce samples (>=2).
- INIT, '0, NUM_STAGES-bit reset value of the enables.
- H_ACT, 1280, active width; sizes the x field of the pack.
- V_ACT, 720, active height; sizes the y field of the pack.
- PACK_W, 3*8+4+$clog2(H_ACT)+$clog2(V_ACT), pack width (derived, not overridable).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- keys  input  NUM_STAGES  raw push keys, asynchronous, high = pressed.
- i_pack  input  PACK_W  video pack {r,g,b,vs,hs,de,rsv,x,y}.
- o_pack  output  PACK_W  i_pack delayed 1 cycle.
- o_en  output  NUM_STAGES  committed stage enables, aligned to o_pack.
- o_pend  output  NUM_STAGES  pending enables (toggled, not yet committed).
- o_wb_update  output  1  one-cycle pulse at each committed frame start.
- o_frame_cnt  output  16  frames since the last enable change, saturating.

Behaviour:
- Reset, sampled on rising clk: o_pack=0, o_en=INIT, o_pend=INIT, o_wb_update=0, o_frame_cnt=0, tick counter=0, key history=0, debounced levels=0.
- Key input path: 2-FF synchroniser per key.
- Tick counter: shared, counts 0..TICK-1 and wraps. tick_hit is asserted when the count equals TICK-1.
- On tick_hit, each key's synchronised level shifts into a 2-bit history.
  - Debounced level goes to 1 when the history is 11 and to 0 when it is 00; otherwise it holds.
- A debounced 0->1 edge toggles the key's o_pend bit on the same cycle. There is no auto-repeat while the key is held.
- Frame start: vs (pack field, see package) rising edge, detected against the previous-cycle vs.
- Per-frame state machine, states IDLE and ARMED.
  - IDLE: o_pend == o_en. Entered from ARMED after a commit.
  - IDLE -> ARMED: on the cycle o_pend first differs from o_en.
  - ARMED -> IDLE: on a frame start, o_en <= o_pend (commit).
  - Any frame start, in either state: o_wb_update pulses high for 1 cycle, coincident with the first o_pack cycle carrying vs=1.
- o_frame_cnt:
  - Cleared to 0 on a commit.
  - Otherwise incremented on each frame start and saturates at 16'hFFFF.
- Simultaneous events:
  - A toggle landing on the same cycle as a frame start is not included in that commit. The commit uses the pre-toggle o_pend; the new value commits at the next frame start.
  - A double toggle before a frame start returns o_pend equal to o_en: the FSM drops back to IDLE and nothing commits.
- Pack latency is exactly 1 cycle; o_en changes on the same clock edge that o_pack first shows vs=1.
- Reset mid-frame: all state is cleared immediately. The next vs rising edge is a valid frame start; vs held high at reset release is not a frame start.

Optional Feature:
- Macro: FRAME_STAGE_SYNC_EN.
- Defined: frame-boundary commit as described above.
- Undefined:
  - o_en follows o_pend with 1 cycle latency and no FSM.
  - o_frame_cnt still counts frames and clears on any o_en change.
  - o_wb_update still pulses on every frame start.

Decomposition:
- Package frame_pkg holds:
  - pack field offsets as localparam functions of H_ACT/V_ACT: VS_BIT, HS_BIT, DE_BIT, RGB_MSB, X_LSB, Y_LSB;
  - the pack width function;
  - state typedef enum logic {IDLE, ARMED} stage_state_t.
- Sub-module key_debounce, instantiated with a NUM_STAGES-wide vector; contains the synchroniser, history and debounced-edge logic.
- The tick counter lives in key_debounce and is shared across keys.

Test Plan:
- Reset, TICK=4, INIT=4'b0101 -> o_en=o_pend=4'b0101, o_wb_update=0, o_frame_cnt=0.
- Toggle commit: key[1] held high 12 cycles -> o_pend=4'b0111 after the second tick_hit; o_en stays 4'b0101 until the next vs rise, then becomes 4'b0111 with o_frame_cnt=0 and o_wb_update high for 1 cycle.
- Glitch rejection: key[2] high for 3 cycles spanning only one tick_hit -> o_pend unchanged.
- Double press before frame start: key[0] pressed twice -> o_pend returns to INIT, no commit, and o_frame_cnt keeps incrementing (3 frames -> 3).
- Race: debounced edge on the same cycle as a vs rise -> o_en unchanged that frame; commit happens at the following vs rise.
- Latency: random pack stream -> o_pack == i_pack delayed 1 cycle on every cycle. With FRAME_STAGE_SYNC_EN undefined, o_en == o_pend delayed 1 cycle.
